// File: rtl/iterative_divider_unit_if.sv
// Divider request/response bundle shared by the pipeline stall control
// (master) and the iterative divider (slave).
interface iterative_divider_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (output start, signed_op, dividend, divisor,
                   input  busy, done, quotient, remainder, div_by_zero);
   modport slave  (input  start, signed_op, dividend, divisor,
                   output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/iterative_divider_unit.sv
// Multi-cycle 32-bit restoring divider with RISC-V DIV/DIVU/REM/REMU results.
// One quotient bit per clock through a carry-lookahead trial subtractor.
// Optional build macro DIVIDER_EARLY_OUT_EN: skip the iteration when
// |dividend| < |divisor| (result is then Q=0, R=|dividend|).

// 32-bit adder/subtractor built from 4-bit lookahead slices; mode=1 inverts b.
module div_cla_adder #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH-1:0] bx, g, p;
   logic [WIDTH:0]   c;

   assign bx   = b ^ {WIDTH{mode}};
   assign g    = a & bx;
   assign p    = a ^ bx;
   assign c[0] = cin;

   // Each slice resolves its four carries from the slice carry-in alone.
   for (genvar s = 0; s < WIDTH/4; s++) begin : g_slice
      localparam int B = 4*s;
      assign c[B+1] = g[B] | (p[B] & c[B]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & c[B]);
      assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B])
                    | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
   end

   assign sum  = p ^ c[WIDTH-1:0];
   assign cout = c[WIDTH];
endmodule

module iterative_divider_unit #(parameter int WIDTH = 32) (
   input logic                    clk,
   input logic                    rst,
   iterative_divider_unit_if.slave bus
);
   if (WIDTH != 32) begin : g_width_chk
      $error("iterative_divider_unit: WIDTH must be 32");
   end

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
   logic             done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;

   logic [WIDTH-1:0] abs_dvd, abs_dvs, shl, add_a, add_b, add_sum;
   logic             add_cout, ok;

   assign abs_dvd = (bus.signed_op & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
   assign abs_dvs = (bus.signed_op & bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
   assign shl     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
   // Bit 31 of R set means the shifted value has a 33rd bit, so it always fits.
   assign ok      = r_q[WIDTH-1] | add_cout;

   // Adder is shared: magnitude compare in IDLE, trial subtract in CALC.
   always_comb begin
      add_a = shl;
      add_b = d_q;
      if (state_q == S_IDLE) begin
         add_a = abs_dvd;
         add_b = abs_dvs;
      end
   end

   div_cla_adder #(.WIDTH(WIDTH)) u_sub (
      .a(add_a), .b(add_b), .mode(1'b1), .cin(1'b1), .sum(add_sum), .cout(add_cout)
   );

   // Next-state and datapath updates for IDLE/CALC/FIX.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      q_d         = q_q;
      r_d         = r_q;
      d_d         = d_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      zero_d      = zero_q;
      done_d      = 1'b0;
      dbz_d       = dbz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               qneg_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
               rneg_d = bus.signed_op & bus.dividend[WIDTH-1];
               q_d    = abs_dvd;
               r_d    = '0;
               d_d    = abs_dvs;
               cnt_d  = '0;
               zero_d = (bus.divisor == '0);
               if (bus.divisor == '0) begin
                  // Q is idle on this path, so it carries the raw dividend to FIX.
                  q_d     = bus.dividend;
                  state_d = S_FIX;
               end else begin
`ifdef DIVIDER_EARLY_OUT_EN
                  if (!add_cout) begin
                     q_d     = '0;
                     r_d     = abs_dvd;
                     state_d = S_FIX;
                  end else begin
                     state_d = S_CALC;
                  end
`else
                  state_d = S_CALC;
`endif
               end
            end
         end
         S_CALC: begin
            r_d   = ok ? add_sum : shl;
            q_d   = {q_q[WIDTH-2:0], ok};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (zero_q) begin
               quotient_d  = '1;
               remainder_d = q_q;
               dbz_d       = 1'b1;
            end else begin
               quotient_d  = qneg_q ? -q_q : q_q;
               remainder_d = rneg_q ? -r_q : r_q;
               dbz_d       = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and result registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         q_q         <= '0;
         r_q         <= '0;
         d_q         <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         zero_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         r_q         <= r_d;
         d_q         <= d_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         zero_q      <= zero_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_iterative_divider_unit.sv
// Directed-vector bench for iterative_divider_unit: table of hand-computed
// results, latency, ignored start while busy, mid-op reset, back-to-back ops.
module tb_iterative_divider_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   iterative_divider_unit_if bus ();
   iterative_divider_unit dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] aa, ab;
      aa = (sgn && a[31]) ? -a : a;
      ab = (sgn && b[31]) ? -b : b;
      if (b == 0) return 2;
`ifdef DIVIDER_EARLY_OUT_EN
      if (aa < ab) return 2;
`endif
      return 34;
   endfunction

   task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
      logic signed [31:0] sa, sb;
      sa = a; sb = b; dz = 1'b0;
      if (b == 0) begin q = '1; r = a; dz = 1'b1; end
      else if (!sgn) begin q = a / b; r = a % b; end
      else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = a; r = 0; end
      else begin q = sa / sb; r = sa % sb; end
   endtask

   // Entered #1 after a rising edge; raises start and waits for done.
   // poke_at>0 pulses an extra start with other operands while busy.
   task automatic do_op(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int poke_at);
      int n = 0;
      bus.start = 1'b1; bus.signed_op = sgn; bus.dividend = a; bus.divisor = b;
      while (1) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            bus.start = 1'b0;
            chk({nm, " busy"}, {31'd0, bus.busy}, 32'd1);
         end
         if (poke_at > 0 && n == poke_at) begin
            bus.start = 1'b1; bus.signed_op = ~sgn;
            bus.dividend = 32'h00000063; bus.divisor = 32'h00000002;
         end
         if (poke_at > 0 && n == poke_at + 1) bus.start = 1'b0;
         if (bus.done) break;
         if (n >= 100) break;
      end
      if (!bus.done) begin
         total++; bad++;
         $display("FAIL %s timeout: no done after %0d cycles", nm, n);
      end else begin
         chk({nm, " lat"}, n, exp_lat(sgn, a, b));
         chk({nm, " q"}, bus.quotient, eq);
         chk({nm, " r"}, bus.remainder, er);
         chk({nm, " dz"}, {31'd0, bus.div_by_zero}, {31'd0, edz});
      end
   endtask

   vec_t tbl[15];

   initial begin
      logic [31:0] mq, mr, a, b;
      logic        mdz, sg;
      tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
      tbl[2]  = '{1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1};
      tbl[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
      tbl[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
      tbl[5]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
      tbl[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
      tbl[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
      tbl[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
      tbl[9]  = '{1'b1, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1};
      tbl[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
      tbl[11] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      tbl[12] = '{1'b0, 32'hFFFFFFFE,   32'd3,          32'h55555554,   32'd2,          1'b0};
      tbl[13] = '{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
      tbl[14] = '{1'b1, 32'hFFFFFFFB,   32'd9,          32'd0,          32'hFFFFFFFB,   1'b0};

      bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {31'd0, bus.busy}, 32'd0);
      chk("rst done", {31'd0, bus.done}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle q", bus.quotient, 32'd0);
      chk("idle r", bus.remainder, 32'd0);
      chk("idle dz", {31'd0, bus.div_by_zero}, 32'd0);
      chk("idle done", {31'd0, bus.done}, 32'd0);

      // Table vectors run back to back: each start lands in the previous done cycle.
      for (int i = 0; i < 15; i++)
         do_op($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
               tbl[i].q, tbl[i].r, tbl[i].dz, 0);

      // Results hold through the done cycle even while a new start is accepted.
      do_op("b2b_a", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 0);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd0;
      #2;
      chk("b2b hold q", bus.quotient, 32'd333);
      chk("b2b hold r", bus.remainder, 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b accepted", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
      chk("b2b dz done", {31'd0, bus.done}, 32'd1);
      chk("b2b dz r", bus.remainder, 32'd50);

      // Start while busy is ignored; the first operation completes untouched.
      @(posedge clk); #1;
      do_op("poke", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 5);
      @(posedge clk); #1;
      chk("poke not queued", {31'd0, bus.busy}, 32'd0);

      // Reset in CALC cycle 10 clears everything immediately.
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid rst busy", {31'd0, bus.busy}, 32'd0);
      chk("mid rst done", {31'd0, bus.done}, 32'd0);
      chk("mid rst q", bus.quotient, 32'd0);
      chk("mid rst r", bus.remainder, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_op("after rst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 0);

      // Random vectors against the behavioural model.
      for (int i = 0; i < 24; i++) begin
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom >> $urandom_range(0, 31);
         if (i % 8 == 3) b = 32'd0;
         ref_div(sg, a, b, mq, mr, mdz);
         do_op($sformatf("rnd%0d", i), sg, a, b, mq, mr, mdz, 0);
      end

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
